rf_access_sequencer: RTL and testbench
======================================

// Module: rf_access_sequencer
// PURPOSE
//  Sequences and shares the single-read/single-write-port register file between the
//  decode stage (two operands per instruction) and a debug read requester. Issues rs1 then
//  rs2 reads over the one read port and returns both operands together. Passes writeback to the
//  write port with x0 suppression. Sits between decoder/writeback and regfile in the core top.
// PARAMETERS
//  XLEN    32  data width of register file entries
//  REG_AW  5   register index width (2**REG_AW registers)
// PORTS
//  clk              in   1       core clock; all state updates on rising edge
//  rst              in   1       synchronous, active-high reset
//  dec_req_valid    in   1       decode requests operands; held until accepted
//  dec_rs1/dec_rs2  in   REG_AW  source register indices
//  dec_req_ready    out  1       decode request accepted this cycle
//  op_valid         out  1       one-cycle pulse: op_a/op_b valid
//  op_a/op_b        out  XLEN    rs1/rs2 operand values; held until next op_valid
//  dbg_req_valid    in   1       debug read request; held until accepted
//  dbg_reg          in   REG_AW  debug register index
//  dbg_req_ready    out  1       debug request accepted this cycle
//  dbg_rdata_valid  out  1       one-cycle pulse: dbg_rdata valid
//  dbg_rdata        out  XLEN    debug read value; held until next pulse
//  wb_valid/wb_rd/wb_data  in  1/REG_AW/XLEN  writeback request
//  rf_read_en/rf_read_reg  out 1/REG_AW       regfile read port
//  rf_read_data            in  XLEN           regfile data, 1 cycle after rf_read_en
//  rf_write_en/rf_write_reg/rf_write_data  out 1/REG_AW/XLEN  regfile write port
// BEHAVIOUR
//  - Reset: state IDLE, last_grant=DBG (decode wins first tie), all outputs 0; in-flight
//    request dropped, requester re-presents (valid still held -> re-accepted).
//  - FSM: IDLE -> RD1 -> RD2 -> CAP2 -> IDLE (decode); IDLE -> DRD -> DCAP -> IDLE (debug).
//  - IDLE: ready high only for the granted requester; both valid -> grant the one not in
//    last_grant; acceptance latches indices and updates last_grant. Readies low outside IDLE.
//  - Decode timing (accept in cycle T): T+1 RD1 read rs1; T+2 RD2 read rs2, latch op_a;
//    T+3 CAP2 latch op_b; T+4 op_valid=1 (IDLE, new acceptance possible). Max 1 per 4 cycles.
//  - Debug timing (accept T): T+1 DRD read; T+2 DCAP latch; T+3 dbg_rdata_valid=1.
//  - rf_read_en high only in RD1/RD2/DRD; rf_read_reg=0 otherwise.
//  - Index 0 reads: regfile still accessed, latched value forced to 0.
//  - Write port combinational pass-through every cycle regardless of state:
//    rf_write_en = wb_valid && wb_rd!=0; reg/data = wb_rd/wb_data. No backpressure on writeback.
//  - Regfile semantics: read and write to same index in same cycle returns OLD value.
// CONFIGURATION
//  RF_BYPASS_EN defined: if rf_write_en is high and rf_write_reg equals rf_read_reg in a read-
//   issue cycle (RD1/RD2/DRD), wb_data is registered and substituted for rf_read_data at latch.
//  RF_BYPASS_EN undefined: latched value is always rf_read_data (old value); no bypass regs.
// STRUCTURE
//  - Package rf_seq_pkg: XLEN/REG_AW defaults, state_t enum {IDLE,RD1,RD2,CAP2,DRD,DCAP},
//    grant_t enum {GNT_DEC,GNT_DBG}.
//  - Sub-module rf_req_arbiter: 2-way round-robin; inputs two valids + enable (IDLE),
//    outputs grant one-hot; owns last_grant register.
// TESTING
//  - x1=0x11,x2=0x22; dec rs1=1,rs2=2 at T -> ready at T, op_valid at T+4, op_a=0x11, op_b=0x22.
//  - dec rs1=0,rs2=2 with x0 read data 0xDEAD forced by model -> op_a=0, op_b=0x22.
//  - dec and dbg valid same cycle after reset -> decode granted; dbg accepted at T+4,
//    dbg_rdata_valid at T+7; next tie goes to decode only after a debug grant.
//  - wb x3=0x33 during RD1 reading x3: bypass on -> op_a=0x33; off -> old value.
//  - wb_valid, wb_rd=0, wb_data=0xFF -> rf_write_en stays 0; wb x5 in any state -> written same cycle.
//  - rst pulsed in RD2 -> next cycle IDLE, outputs 0, no op_valid; held request re-accepted.

Source files
------------

// File: rtl/rf_access_sequencer_pkg.sv
// Shared definitions for the register-file access sequencer: default widths, FSM and grant encodings.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rf_seq_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        CAP2 = 3'd3,
        DRD  = 3'd4,
        DCAP = 3'd5
    } state_t;

    // Enum value doubles as the bit position in the one-hot grant vector.
    typedef enum logic {
        GNT_DEC = 1'b0,
        GNT_DBG = 1'b1
    } grant_t;

endpackage

// File: rtl/rf_access_sequencer_if.sv
// Bundle of decode, debug, writeback and regfile-port signals around the access sequencer.
// Latency: none (wiring only).
// Backpressure: dec/dbg use valid/ready; writeback and regfile ports have none.
interface rf_access_sequencer_if
    import rf_seq_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
);
    logic              dec_req_valid;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic              dec_req_ready;
    logic              op_valid;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;

    logic              dbg_req_valid;
    logic [REG_AW-1:0] dbg_reg;
    logic              dbg_req_ready;
    logic              dbg_rdata_valid;
    logic [XLEN-1:0]   dbg_rdata;

    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic              rf_read_en;
    logic [REG_AW-1:0] rf_read_reg;
    logic [XLEN-1:0]   rf_read_data;
    logic              rf_write_en;
    logic [REG_AW-1:0] rf_write_reg;
    logic [XLEN-1:0]   rf_write_data;

    // Sequencer side.
    modport slave (
        input  dec_req_valid, dec_rs1, dec_rs2,
        output dec_req_ready, op_valid, op_a, op_b,
        input  dbg_req_valid, dbg_reg,
        output dbg_req_ready, dbg_rdata_valid, dbg_rdata,
        input  wb_valid, wb_rd, wb_data,
        output rf_read_en, rf_read_reg,
        input  rf_read_data,
        output rf_write_en, rf_write_reg, rf_write_data
    );

    // Requester / regfile side.
    modport master (
        output dec_req_valid, dec_rs1, dec_rs2,
        input  dec_req_ready, op_valid, op_a, op_b,
        output dbg_req_valid, dbg_reg,
        input  dbg_req_ready, dbg_rdata_valid, dbg_rdata,
        output wb_valid, wb_rd, wb_data,
        input  rf_read_en, rf_read_reg,
        output rf_read_data,
        input  rf_write_en, rf_write_reg, rf_write_data
    );

endinterface

// File: rtl/rf_access_sequencer_arbiter.sv
// Two-way round-robin arbiter between decode and debug read requests.
// Latency: grant is combinational from the valids; last_grant updates on the next edge.
// Backpressure: grants nothing while disabled; the loser keeps its valid held.
module rf_req_arbiter
    import rf_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_dec_vld,
    input  logic       i_dbg_vld,
    output logic [1:0] o_gnt
);

    grant_t r_last;

    // Pick a winner; a tie goes to whichever side did not win last time.
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_dec_vld && i_dbg_vld) begin
                o_gnt = (r_last == GNT_DBG) ? 2'b01 : 2'b10;
            end else begin
                o_gnt = {i_dbg_vld, i_dec_vld};
            end
        end
    end

    // Remember the last side granted; reset state lets decode win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= GNT_DBG;
        end else if (o_gnt[GNT_DEC]) begin
            r_last <= GNT_DEC;
        end else if (o_gnt[GNT_DBG]) begin
            r_last <= GNT_DBG;
        end
    end

endmodule

// File: rtl/rf_access_sequencer.sv
// Shares one regfile read port between decode (rs1 then rs2) and debug reads; passes writeback through with x0 suppressed. Optional macro: RF_BYPASS_EN.
// Latency: decode accept T -> op_valid at T+4; debug accept T -> dbg_rdata_valid at T+3; write port is combinational.
// Backpressure: requesters hold valid until ready, which is only offered in IDLE; writeback is never stalled.
module rf_access_sequencer
    import rf_seq_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
)(
    input  logic                  clk,
    input  logic                  rst,
    rf_access_sequencer_if.slave  bus
);

    localparam logic [2:0] S_IDLE = 3'(IDLE);
    localparam logic [2:0] S_RD1  = 3'(RD1);
    localparam logic [2:0] S_RD2  = 3'(RD2);
    localparam logic [2:0] S_CAP2 = 3'(CAP2);
    localparam logic [2:0] S_DRD  = 3'(DRD);
    localparam logic [2:0] S_DCAP = 3'(DCAP);

    logic [2:0]        r_state;
    // r_rs1 also carries the debug index during a debug read.
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd_idx;
    logic [XLEN-1:0]   r_op_a_lat;
    logic              r_op_valid;
    logic [XLEN-1:0]   r_op_a;
    logic [XLEN-1:0]   r_op_b;
    logic              r_dbg_vld;
    logic [XLEN-1:0]   r_dbg_rdata;

    logic [1:0]        w_gnt;
    logic              w_en;
    logic              w_dec_acc;
    logic              w_dbg_acc;
    logic              w_rd_en;
    logic [REG_AW-1:0] w_rd_reg;
    logic              w_wr_en;
    logic [XLEN-1:0]   w_rd_src;
    logic [XLEN-1:0]   w_rd_val;

    // Arbitration only while idle and not being reset, so a reset cycle never accepts.
    assign w_en = (r_state == S_IDLE) && !rst;

    rf_req_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_en),
        .i_dec_vld (bus.dec_req_valid),
        .i_dbg_vld (bus.dbg_req_valid),
        .o_gnt     (w_gnt)
    );

    assign bus.dec_req_ready = w_gnt[GNT_DEC];
    assign bus.dbg_req_ready = w_gnt[GNT_DBG];
    assign w_dec_acc = bus.dec_req_valid && w_gnt[GNT_DEC];
    assign w_dbg_acc = bus.dbg_req_valid && w_gnt[GNT_DBG];

    // Drive the read port only in read-issue states; index is zero otherwise.
    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_reg = '0;
        case (r_state)
            S_RD1: begin
                w_rd_en  = 1'b1;
                w_rd_reg = r_rs1;
            end
            S_RD2: begin
                w_rd_en  = 1'b1;
                w_rd_reg = r_rs2;
            end
            S_DRD: begin
                w_rd_en  = 1'b1;
                w_rd_reg = r_rs1;
            end
            default: begin
                w_rd_en  = 1'b0;
                w_rd_reg = '0;
            end
        endcase
    end

    assign bus.rf_read_en  = w_rd_en;
    assign bus.rf_read_reg = w_rd_reg;

    // Writeback goes straight to the write port; writes to x0 are dropped here.
    assign w_wr_en           = bus.wb_valid && (bus.wb_rd != '0);
    assign bus.rf_write_en   = w_wr_en;
    assign bus.rf_write_reg  = bus.wb_rd;
    assign bus.rf_write_data = bus.wb_data;

`ifdef RF_BYPASS_EN
    logic            r_byp_vld;
    logic [XLEN-1:0] r_byp_dat;

    // Capture a writeback that hits the index being read, since the regfile returns the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_vld <= 1'b0;
            r_byp_dat <= '0;
        end else begin
            r_byp_vld <= w_rd_en && w_wr_en && (bus.wb_rd == w_rd_reg);
            r_byp_dat <= bus.wb_data;
        end
    end

    assign w_rd_src = r_byp_vld ? r_byp_dat : bus.rf_read_data;
`else
    assign w_rd_src = bus.rf_read_data;
`endif

    // x0 always reads as zero whatever the regfile returns.
    assign w_rd_val = (r_rd_idx == '0) ? '0 : w_rd_src;

    // Track which index the data arriving next cycle belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_idx <= '0;
        end else begin
            r_rd_idx <= w_rd_reg;
        end
    end

    // Sequencing FSM: issue reads, latch returned data, pulse the result valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_op_a_lat  <= '0;
            r_op_valid  <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_dbg_vld   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_op_valid <= 1'b0;
            r_dbg_vld  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_dec_acc) begin
                        r_rs1   <= bus.dec_rs1;
                        r_rs2   <= bus.dec_rs2;
                        r_state <= S_RD1;
                    end else if (w_dbg_acc) begin
                        r_rs1   <= bus.dbg_reg;
                        r_state <= S_DRD;
                    end
                end
                S_RD1: r_state <= S_RD2;
                S_RD2: begin
                    r_op_a_lat <= w_rd_val;
                    r_state    <= S_CAP2;
                end
                S_CAP2: begin
                    // Both operands update together with the valid pulse.
                    r_op_a     <= r_op_a_lat;
                    r_op_b     <= w_rd_val;
                    r_op_valid <= 1'b1;
                    r_state    <= S_IDLE;
                end
                S_DRD: r_state <= S_DCAP;
                S_DCAP: begin
                    r_dbg_rdata <= w_rd_val;
                    r_dbg_vld   <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.op_valid        = r_op_valid;
    assign bus.op_a            = r_op_a;
    assign bus.op_b            = r_op_b;
    assign bus.dbg_rdata_valid = r_dbg_vld;
    assign bus.dbg_rdata       = r_dbg_rdata;

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Directed bench for rf_access_sequencer with a behavioural one-read/one-write regfile.
// Latency: checks exact cycle offsets of ready, read issue and result pulses.
// Backpressure: requesters hold valid until ready, as the design expects.
module tb_rf_access_sequencer;
    import rf_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    rf_access_sequencer_if bus ();

    rf_access_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Regfile model: registered read returning the old value; x0 returns junk so forcing is visible.
    logic [31:0] mem [32];
    logic [31:0] rdq = 32'h0;
    always @(posedge clk) begin
        if (bus.rf_read_en)
            rdq <= (bus.rf_read_reg == 5'd0) ? 32'hDEAD : mem[bus.rf_read_reg];
        if (bus.rf_write_en)
            mem[bus.rf_write_reg] <= bus.rf_write_data;
    end
    assign bus.rf_read_data = rdq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a decode request in the current cycle and check it through to op_valid at T+4.
    task automatic dec_op(input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] ea, input logic [31:0] eb, input string tag);
        bus.dec_req_valid = 1'b1;
        bus.dec_rs1 = a;
        bus.dec_rs2 = b;
        #1;
        chk({tag, ".rdy_T"}, 32'(bus.dec_req_ready), 32'd1);
        tick();
        bus.dec_req_valid = 1'b0;
        #1;
        chk({tag, ".rd_en_T1"}, 32'(bus.rf_read_en), 32'd1);
        chk({tag, ".rd_reg_T1"}, 32'(bus.rf_read_reg), 32'(a));
        chk({tag, ".rdy_T1"}, 32'(bus.dec_req_ready), 32'd0);
        tick();
        chk({tag, ".rd_reg_T2"}, 32'(bus.rf_read_reg), 32'(b));
        tick();
        chk({tag, ".opv_T3"}, 32'(bus.op_valid), 32'd0);
        chk({tag, ".rd_en_T3"}, 32'(bus.rf_read_en), 32'd0);
        tick();
        chk({tag, ".opv_T4"}, 32'(bus.op_valid), 32'd1);
        chk({tag, ".op_a"}, bus.op_a, ea);
        chk({tag, ".op_b"}, bus.op_b, eb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_byp;
        for (int i = 0; i < 32; i++) mem[i] = 32'(i);
        mem[1] = 32'h11;
        mem[2] = 32'h22;
        bus.dec_req_valid = 1'b0;
        bus.dec_rs1 = '0;
        bus.dec_rs2 = '0;
        bus.dbg_req_valid = 1'b0;
        bus.dbg_reg = '0;
        bus.wb_valid = 1'b0;
        bus.wb_rd = '0;
        bus.wb_data = '0;

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst.op_valid", 32'(bus.op_valid), 32'd0);
        chk("rst.op_a", bus.op_a, 32'd0);
        chk("rst.op_b", bus.op_b, 32'd0);
        chk("rst.dbg_vld", 32'(bus.dbg_rdata_valid), 32'd0);
        chk("rst.dbg_rdata", bus.dbg_rdata, 32'd0);
        chk("rst.rd_en", 32'(bus.rf_read_en), 32'd0);
        chk("rst.rd_reg", 32'(bus.rf_read_reg), 32'd0);
        chk("rst.wr_en", 32'(bus.rf_write_en), 32'd0);
        chk("rst.dec_rdy", 32'(bus.dec_req_ready), 32'd0);

        // Basic operand fetch, then x0 forced to zero despite the regfile returning 0xDEAD.
        dec_op(5'd1, 5'd2, 32'h11, 32'h22, "dec12");
        dec_op(5'd0, 5'd2, 32'h0, 32'h22, "dec02");

        // Tie straight after reset: decode first, debug served at T+4, data at T+7.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dec_req_valid = 1'b1;
        bus.dec_rs1 = 5'd1;
        bus.dec_rs2 = 5'd2;
        bus.dbg_req_valid = 1'b1;
        bus.dbg_reg = 5'd2;
        #1;
        chk("tie1.dec_rdy", 32'(bus.dec_req_ready), 32'd1);
        chk("tie1.dbg_rdy", 32'(bus.dbg_req_ready), 32'd0);
        tick();
        bus.dec_req_valid = 1'b0;
        tick();
        chk("tie1.dbg_rdy_T2", 32'(bus.dbg_req_ready), 32'd0);
        tick();
        tick();
        chk("tie1.opv_T4", 32'(bus.op_valid), 32'd1);
        chk("tie1.op_a", bus.op_a, 32'h11);
        chk("tie1.op_b", bus.op_b, 32'h22);
        chk("tie1.dbg_rdy_T4", 32'(bus.dbg_req_ready), 32'd1);
        tick();
        bus.dbg_req_valid = 1'b0;
        #1;
        chk("tie1.dbg_rd_en", 32'(bus.rf_read_en), 32'd1);
        chk("tie1.dbg_rd_reg", 32'(bus.rf_read_reg), 32'd2);
        tick();
        chk("tie1.dbgv_T6", 32'(bus.dbg_rdata_valid), 32'd0);
        tick();
        chk("tie1.dbgv_T7", 32'(bus.dbg_rdata_valid), 32'd1);
        chk("tie1.dbg_rdata", bus.dbg_rdata, 32'h22);

        // Next tie after a debug grant goes to decode; the one after that to debug.
        bus.dec_req_valid = 1'b1;
        bus.dec_rs1 = 5'd2;
        bus.dec_rs2 = 5'd1;
        bus.dbg_req_valid = 1'b1;
        bus.dbg_reg = 5'd1;
        #1;
        chk("tie2.dec_rdy", 32'(bus.dec_req_ready), 32'd1);
        chk("tie2.dbg_rdy", 32'(bus.dbg_req_ready), 32'd0);
        tick();
        bus.dec_req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("tie2.opv", 32'(bus.op_valid), 32'd1);
        chk("tie2.op_a", bus.op_a, 32'h22);
        chk("tie2.op_b", bus.op_b, 32'h11);
        bus.dec_req_valid = 1'b1;
        #1;
        chk("tie3.dec_rdy", 32'(bus.dec_req_ready), 32'd0);
        chk("tie3.dbg_rdy", 32'(bus.dbg_req_ready), 32'd1);
        tick();
        bus.dec_req_valid = 1'b0;
        bus.dbg_req_valid = 1'b0;
        tick();
        tick();
        chk("tie3.dbgv", 32'(bus.dbg_rdata_valid), 32'd1);
        chk("tie3.dbg_rdata", bus.dbg_rdata, 32'h11);

        // Writeback pass-through: x0 suppressed, x5 written in the same cycle.
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'd0;
        bus.wb_data = 32'hFF;
        #1;
        chk("wb0.wr_en", 32'(bus.rf_write_en), 32'd0);
        tick();
        bus.wb_rd = 5'd5;
        bus.wb_data = 32'h55;
        #1;
        chk("wb5.wr_en", 32'(bus.rf_write_en), 32'd1);
        chk("wb5.wr_reg", 32'(bus.rf_write_reg), 32'd5);
        chk("wb5.wr_data", bus.rf_write_data, 32'h55);
        tick();
        bus.wb_valid = 1'b0;

        // Writeback to x3 while RD1 reads x3; a write in RD2 still reaches the port.
`ifdef RF_BYPASS_EN
        exp_byp = 32'h33;
`else
        exp_byp = 32'h3;
`endif
        bus.dec_req_valid = 1'b1;
        bus.dec_rs1 = 5'd3;
        bus.dec_rs2 = 5'd5;
        #1;
        chk("byp.rdy", 32'(bus.dec_req_ready), 32'd1);
        tick();
        bus.dec_req_valid = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'd3;
        bus.wb_data = 32'h33;
        #1;
        chk("byp.rd_reg_RD1", 32'(bus.rf_read_reg), 32'd3);
        chk("byp.wr_en_RD1", 32'(bus.rf_write_en), 32'd1);
        tick();
        bus.wb_rd = 5'd6;
        bus.wb_data = 32'h66;
        #1;
        chk("byp.wr_en_RD2", 32'(bus.rf_write_en), 32'd1);
        chk("byp.wr_reg_RD2", 32'(bus.rf_write_reg), 32'd6);
        tick();
        bus.wb_valid = 1'b0;
        tick();
        chk("byp.opv", 32'(bus.op_valid), 32'd1);
        chk("byp.op_a", bus.op_a, exp_byp);
        chk("byp.op_b", bus.op_b, 32'h55);

        // The x3 write landed in the regfile; a debug read sees it.
        bus.dbg_req_valid = 1'b1;
        bus.dbg_reg = 5'd3;
        #1;
        chk("dbg3.rdy", 32'(bus.dbg_req_ready), 32'd1);
        tick();
        bus.dbg_req_valid = 1'b0;
        tick();
        tick();
        chk("dbg3.dbgv", 32'(bus.dbg_rdata_valid), 32'd1);
        chk("dbg3.rdata", bus.dbg_rdata, 32'h33);

        // Reset during RD2: request dropped, held valid re-accepted right after.
        bus.dec_req_valid = 1'b1;
        bus.dec_rs1 = 5'd1;
        bus.dec_rs2 = 5'd2;
        #1;
        chk("rstrd2.rdy_T", 32'(bus.dec_req_ready), 32'd1);
        tick();
        tick();
        chk("rstrd2.rd_reg_RD2", 32'(bus.rf_read_reg), 32'd2);
        rst = 1'b1;
        #1;
        chk("rstrd2.rdy_in_rst", 32'(bus.dec_req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstrd2.opv", 32'(bus.op_valid), 32'd0);
        chk("rstrd2.rd_en", 32'(bus.rf_read_en), 32'd0);
        chk("rstrd2.op_a", bus.op_a, 32'd0);
        chk("rstrd2.op_b", bus.op_b, 32'd0);
        chk("rstrd2.reaccept", 32'(bus.dec_req_ready), 32'd1);
        tick();
        bus.dec_req_valid = 1'b0;
        #1;
        chk("rstrd2.no_opv", 32'(bus.op_valid), 32'd0);
        tick();
        tick();
        tick();
        chk("rstrd2.opv_late", 32'(bus.op_valid), 32'd1);
        chk("rstrd2.op_a_late", bus.op_a, 32'h11);
        chk("rstrd2.op_b_late", bus.op_b, 32'h22);
        tick();
        chk("rstrd2.opv_pulse", 32'(bus.op_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
